// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory req/ack plus the decode-side handshake
// and the control/ALU inputs that steer the next PC.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, halted, retired,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, halted, retired,
    output imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches over req/ack, presents the
// instruction to decode and computes the next PC on consume.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] retired_reg;
  logic        req_reg;
  logic        valid_reg;
  logic        halted_reg;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] pc_next;

  always_comb begin
    pc_plus4   = pc_reg + 32'd4;
    branch_off = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    if (bus.jump)
      pc_next = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
    else if (bus.branch && bus.zero)
      pc_next = pc_plus4 + branch_off;
    else
      pc_next = pc_plus4;
  end

  // req comes up on the first clock after reset, so an ack is only taken
  // while a request is actually on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= FETCH;
      pc_reg      <= {RESET_PC[31:2], 2'b00};
      instr_reg   <= 32'h0;
      retired_reg <= 32'h0;
      req_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          req_reg <= 1'b1;
          if (req_reg && bus.imem_ack) begin
            instr_reg <= bus.imem_rdata;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= VALID;
          end
        end
        VALID: begin
          if (bus.instr_ready) begin
            pc_reg      <= pc_next;
            retired_reg <= retired_reg + 32'd1;
            valid_reg   <= 1'b0;
            if (instr_reg[31:26] == HALT_OP) begin
              halted_reg <= 1'b1;
              state_reg  <= HALT;
            end else begin
              req_reg   <= 1'b1;
              state_reg <= FETCH;
            end
          end
        end
        HALT: begin
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
        default: state_reg <= HALT;
      endcase
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.pc          = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.opcode      = instr_reg[31:26];
  assign bus.instr_valid = valid_reg;
  assign bus.halted      = halted_reg;
  assign bus.retired     = retired_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program table walked through the fetch stage with
// a latency-programmable memory model and a fetch scoreboard.
module tb_instr_fetch;

  localparam int NV = 15;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          lat;
    int          stall;
    logic        zero;
    logic        bforce;
    logic [31:0] exp_next;
    logic        halt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0), .HALT_OP(6'b111111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t        vecs [NV];
  sb_t         sb_q [$];
  int          checks = 0;
  int          failures = 0;

  logic        ready_drv = 1'b0;
  logic        zero_drv = 1'b0;
  logic        bforce_drv = 1'b0;
  int          lat_drv = 0;
  int          wait_cnt;
  logic [31:0] rdata_drv;

  // Memory model: ack once req has been held for lat_drv cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  always_comb begin
    rdata_drv = 32'hDEAD_BEEF;
    for (int k = 0; k < NV; k++)
      if (vecs[k].addr == bus.imem_addr) rdata_drv = vecs[k].word;
  end

  assign bus.imem_ack    = bus.imem_req && (wait_cnt == lat_drv);
  assign bus.imem_rdata  = rdata_drv;
  assign bus.instr_ready = ready_drv;
  assign bus.jump        = (bus.opcode == 6'b000010);
  assign bus.branch      = (bus.opcode == 6'b000100) || bforce_drv;
  assign bus.zero        = zero_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_opcode", {26'b0, bus.opcode}, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);
    chk("rst_retired", bus.retired, 32'h0);
  endtask

  // Entered and left on a falling edge.
  task automatic run_vec(input vec_t v, input int exp_ret);
    sb_t         e;
    int          n_req;
    logic        got;
    logic [31:0] held;
    lat_drv    = v.lat;
    zero_drv   = v.zero;
    bforce_drv = v.bforce;
    ready_drv  = 1'b0;
    sb_q.push_back('{addr: v.addr, word: v.word});
    n_req = 0;
    got   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.instr_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.imem_req) begin
        n_req++;
        chk("fetch_addr", bus.imem_addr, v.addr);
      end
      @(negedge clk);
    end
    chk("valid_timeout", {31'b0, got}, 32'h1);
    chk("req_cycles", n_req, v.lat + 1);
    e = sb_q.pop_front();
    chk("sb_pc", bus.pc, e.addr);
    chk("sb_instr", bus.instr, e.word);
    chk("opcode", {26'b0, bus.opcode}, {26'b0, e.word[31:26]});
    chk("req_in_valid", {31'b0, bus.imem_req}, 32'h0);
    held = bus.instr;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("stall_instr", bus.instr, held);
      chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
      chk("stall_pc", bus.pc, v.addr);
      chk("stall_retired", bus.retired, exp_ret - 1);
    end
    ready_drv = 1'b1;
    @(negedge clk);
    ready_drv = 1'b0;
    chk("next_pc", bus.pc, v.exp_next);
    chk("retired", bus.retired, exp_ret);
    chk("halted", {31'b0, bus.halted}, {31'b0, v.halt});
    chk("valid_after", {31'b0, bus.instr_valid}, 32'h0);
    chk("req_after", {31'b0, bus.imem_req}, {31'b0, !v.halt});
    $display("txn pc=%h instr=%h next_pc=%h retired=%0d", v.addr, v.word, bus.pc, bus.retired);
  endtask

  initial begin
    //            addr          word          lat stall zero  bforce exp_next      halt
    vecs[0]  = '{32'h0000_0000, 32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
    vecs[1]  = '{32'h0000_0004, 32'h0800_0004, 3, 0, 1'b0, 1'b0, 32'h0000_0010, 1'b0};
    vecs[2]  = '{32'h0000_0010, 32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 32'h0000_000C, 1'b0};
    vecs[3]  = '{32'h0000_000C, 32'h0800_0004, 1, 5, 1'b0, 1'b0, 32'h0000_0010, 1'b0};
    vecs[4]  = '{32'h0000_0010, 32'h1000_FFFE, 0, 0, 1'b0, 1'b0, 32'h0000_0014, 1'b0};
    vecs[5]  = '{32'h0000_0014, 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 32'h0FFF_FFFC, 1'b0};
    vecs[6]  = '{32'h0FFF_FFFC, 32'h0000_0000, 0, 0, 1'b1, 1'b0, 32'h1000_0000, 1'b0};
    vecs[7]  = '{32'h1000_0000, 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 32'h1FFF_FFFC, 1'b0};
    vecs[8]  = '{32'h1FFF_FFFC, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h2000_0000, 1'b0};
    vecs[9]  = '{32'h2000_0000, 32'h0BFF_FFFF, 2, 0, 1'b0, 1'b0, 32'h2FFF_FFFC, 1'b0};
    vecs[10] = '{32'h2FFF_FFFC, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h3000_0000, 1'b0};
    vecs[11] = '{32'h3000_0000, 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 32'h3FFF_FFFC, 1'b0};
    vecs[12] = '{32'h3FFF_FFFC, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h4000_0000, 1'b0};
    vecs[13] = '{32'h4000_0000, 32'h0800_0010, 0, 0, 1'b1, 1'b1, 32'h4000_0040, 1'b0};
    vecs[14] = '{32'h4000_0040, 32'hFC00_0000, 2, 0, 1'b0, 1'b0, 32'h4000_0044, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i], i + 1);

    // HALT: ready and memory are ignored, everything frozen.
    ready_drv = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      chk("halt_halted", {31'b0, bus.halted}, 32'h1);
      chk("halt_req", {31'b0, bus.imem_req}, 32'h0);
      chk("halt_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("halt_pc", bus.pc, 32'h4000_0044);
      chk("halt_retired", bus.retired, 32'd15);
    end
    ready_drv = 1'b0;

    // Reset out of HALT, fetch one instruction, then abort the next fetch.
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    run_vec(vecs[0], 1);
    lat_drv = 5;
    @(negedge clk);
    @(negedge clk);
    chk("abort_req_before", {31'b0, bus.imem_req}, 32'h1);
    chk("abort_addr_before", bus.imem_addr, 32'h4);
    #2 reset = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the main control decoder in the single-cycle MIPS core.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Presents the held instruction and its opcode field to decode.
- Computes the next PC from the decoder's branch/jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
HALT_OP, 6'b111111, opcode that stops fetching after it is consumed.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word-aligned fetch address; equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  held instruction for decode
opcode  output  6  instr[31:26], drives the control decoder opcode input
instr_valid  output  1  instr holds a valid instruction
instr_ready  input  1  decode/execute consumes instr this cycle
branch  input  1  from control decoder
zero  input  1  from ALU
jump  input  1  from control decoder
pc  output  32  address of the current instruction
halted  output  1  HALT_OP consumed; fetching stopped
retired  output  32  count of consumed instructions

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, halted=0, retired=0. imem_req=1 from the first clock after release. Instruction memory shares this reset and drops any pending ack.
- States:
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0. On imem_ack=1, latch imem_rdata into instr and go to VALID. Zero-wait memory is legal: ack may be high in the first FETCH cycle. While waiting, pc and imem_addr stay stable.
  - VALID: imem_req=0, instr_valid=1, and instr is held stable. On instr_ready=1, consume the instruction: update pc to next_pc, increment retired (wraps 32'hFFFF_FFFF to 0), then go to FETCH. If opcode==HALT_OP, go to HALT instead.
  - HALT: imem_req=0, instr_valid=0, halted=1. pc and retired are frozen. The only exit is reset.
- Minimum throughput: one instruction per 2 cycles with zero-wait memory and ready held high.
- imem_ack is ignored outside FETCH. instr_ready is ignored outside VALID.
- next_pc, evaluated combinationally in the consume cycle. pc_plus4 = pc + 4, modulo 2^32.
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. jump has priority over branch.
  - else branch=1 and zero=1: pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
  - otherwise: pc_plus4.
- branch, jump and zero are sampled only in the consume cycle. They are driven combinationally by decode/ALU from the held instr.
- opcode = instr[31:26] at all times, including the 0 value held after reset.
- Reset asserted in any state aborts the current operation immediately. The outstanding request is discarded and no retired update occurs.
- pc bits [1:0] are always 0. There is no misalignment handling.

Test Plan:
1. Release reset with RESET_PC=0, zero-wait memory returning 32'h2008_0005 at 0, instr_ready=1 -> imem_addr=0; cycle 2 instr_valid=1, opcode=6'b001000; after consume pc=4, retired=1.
2. Memory acks 3 cycles after req -> imem_req and imem_addr=pc held constant all 3 cycles; instr_valid rises the cycle after ack; no second request is issued.
3. At pc=32'h10, instr=32'h1000_FFFE (beq, offset -2), branch=1, zero=1 at consume -> pc=32'h0C. Repeat with zero=0 -> pc=32'h14.
4. At pc=32'h4000_0000, instr=32'h0800_0010, jump=1 with branch=1 also high -> pc=32'h4000_0040 (jump wins).
5. Hold instr_ready=0 for 5 cycles in VALID -> instr stable, imem_req=0, pc and retired unchanged; ready=1 then advances exactly once.
6. Consume HALT_OP word -> halted=1, imem_req=0 thereafter. Then assert reset=0 mid-FETCH of another run -> all outputs immediately take reset values and fetching restarts at RESET_PC.
